// File: rtl/modport_bank_ctrl_pkg.sv
// Shared types and field widths for the single-bank DRAM controller.
package modport_bank_ctrl_pkg;

   localparam int T_RC_WIDTH     = 8;
   localparam int T_RCD_WIDTH    = 8;
   localparam int T_RP_WIDTH     = 8;
   localparam int T_RAS_WIDTH    = 8;
   localparam int T_RTP_WIDTH    = 8;
   localparam int T_WTP_WIDTH    = 8;
   localparam int T_CCD_WIDTH    = 8;
   localparam int ROW_OPEN_WIDTH = 8;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_LEN_WIDTH  = 4;
   localparam int DRAM_BA_WIDTH  = 2;
   localparam int DRAM_RA_WIDTH  = 14;
   localparam int DRAM_CA_WIDTH  = 10;

   typedef enum logic {
      ST_CLOSED = 1'b0,
      ST_OPEN   = 1'b1
   } bank_state_t;

endpackage

// File: rtl/modport_bank_timer.sv
// Load-and-count-down timer; holds at zero until the next load.
module modport_bank_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             is_zero
);

   logic [WIDTH-1:0] cnt;

   // Load on the triggering command, otherwise count down and saturate at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign is_zero = (cnt == '0);

endmodule

// File: rtl/modport_bank_ctrl.sv
// Single-bank controller: tracks the open row and issues timed ACT/RD/WR/PRE.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_CLOSED | no row open; waiting for tRP/tRC before ACT
// ST_OPEN   | cur_row open; serving hits, precharging on miss/idle
module modport_bank_ctrl
   import modport_bank_ctrl_pkg::*;
#(
   parameter int BK_ID = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [T_RC_WIDTH-1:0]     t_rc_m1,
   input  logic [T_RCD_WIDTH-1:0]    t_rcd_m1,
   input  logic [T_RP_WIDTH-1:0]     t_rp_m1,
   input  logic [T_RAS_WIDTH-1:0]    t_ras_m1,
   input  logic [T_RTP_WIDTH-1:0]    t_rtp_m1,
   input  logic [T_WTP_WIDTH-1:0]    t_wtp_m1,
   input  logic [T_CCD_WIDTH-1:0]    t_ccd_m1,
   input  logic [ROW_OPEN_WIDTH-1:0] row_open_cnt,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [AXI_ID_WIDTH-1:0]   req_id,
   input  logic [DRAM_RA_WIDTH-1:0]  req_ra,
   input  logic [DRAM_CA_WIDTH-1:0]  req_ca,
   input  logic                      req_wr,
   input  logic [AXI_LEN_WIDTH-1:0]  req_len,
   output logic                      act_gnt,
   output logic                      rd_gnt,
   output logic                      wr_gnt,
   output logic                      pre_gnt,
   output logic                      ref_gnt,
   output logic [DRAM_BA_WIDTH-1:0]  ba,
   output logic [DRAM_RA_WIDTH-1:0]  ra,
   output logic [DRAM_CA_WIDTH-1:0]  ca,
   output logic [AXI_ID_WIDTH-1:0]   id,
   output logic [AXI_LEN_WIDTH-1:0]  len
);

   bank_state_t               state;
   logic [DRAM_RA_WIDTH-1:0]  cur_row;
   logic [ROW_OPEN_WIDTH-1:0] idle_cnt;

   logic rc_z, rcd_z, rp_z, ras_z, rtp_z, wtp_z, ccd_z;
   logic act_c, rd_c, wr_c, pre_c;
   logic row_hit, pre_need;

   modport_bank_timer #(.WIDTH(T_RC_WIDTH)) u_t_rc (
      .clk(clk), .rst_n(rst_n), .load(act_c), .load_val(t_rc_m1), .is_zero(rc_z));
   modport_bank_timer #(.WIDTH(T_RCD_WIDTH)) u_t_rcd (
      .clk(clk), .rst_n(rst_n), .load(act_c), .load_val(t_rcd_m1), .is_zero(rcd_z));
   modport_bank_timer #(.WIDTH(T_RAS_WIDTH)) u_t_ras (
      .clk(clk), .rst_n(rst_n), .load(act_c), .load_val(t_ras_m1), .is_zero(ras_z));
   modport_bank_timer #(.WIDTH(T_RP_WIDTH)) u_t_rp (
      .clk(clk), .rst_n(rst_n), .load(pre_c), .load_val(t_rp_m1), .is_zero(rp_z));
   modport_bank_timer #(.WIDTH(T_RTP_WIDTH)) u_t_rtp (
      .clk(clk), .rst_n(rst_n), .load(rd_c), .load_val(t_rtp_m1), .is_zero(rtp_z));
   modport_bank_timer #(.WIDTH(T_WTP_WIDTH)) u_t_wtp (
      .clk(clk), .rst_n(rst_n), .load(wr_c), .load_val(t_wtp_m1), .is_zero(wtp_z));
   modport_bank_timer #(.WIDTH(T_CCD_WIDTH)) u_t_ccd (
      .clk(clk), .rst_n(rst_n), .load(rd_c | wr_c), .load_val(t_ccd_m1), .is_zero(ccd_z));

   // Grant decode; gated by rst_n so nothing is issued while reset is held.
   always_comb begin
      act_c    = 1'b0;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      pre_c    = 1'b0;
      row_hit  = (req_ra == cur_row);
      pre_need = (req_valid && !row_hit) || (!req_valid && (idle_cnt == row_open_cnt));
      if (rst_n) begin
         case (state)
            ST_CLOSED: act_c = req_valid && rp_z && rc_z;
            ST_OPEN: begin
               if (req_valid && row_hit && rcd_z && ccd_z) begin
                  rd_c = !req_wr;
                  wr_c = req_wr;
               end
               pre_c = pre_need && ras_z && rtp_z && wtp_z;
            end
            default: ;
         endcase
      end
   end

   // Open-row FSM and idle counter feeding the auto-precharge decision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_CLOSED;
         cur_row  <= '0;
         idle_cnt <= '0;
      end else begin
         if (act_c || rd_c || wr_c || pre_c) begin
            idle_cnt <= '0;
         end else if (state == ST_OPEN && idle_cnt < row_open_cnt) begin
            idle_cnt <= idle_cnt + ROW_OPEN_WIDTH'(1);
         end
         if (act_c) begin
            state   <= ST_OPEN;
            cur_row <= req_ra;
         end else if (pre_c) begin
            state <= ST_CLOSED;
         end
      end
   end

   assign act_gnt   = act_c;
   assign rd_gnt    = rd_c;
   assign wr_gnt    = wr_c;
   assign pre_gnt   = pre_c;
   assign ref_gnt   = 1'b0;
   assign req_ready = rd_c | wr_c;
   assign ba        = DRAM_BA_WIDTH'(BK_ID);
   assign ra        = act_c ? req_ra : cur_row;
   assign ca        = req_ca;
   assign id        = req_id;
   assign len       = req_len;

endmodule

// File: tb/tb_modport_bank_ctrl.sv
// Bench for modport_bank_ctrl: cycle-stamp reference model plus directed latency checks.
module tb_modport_bank_ctrl;
   import modport_bank_ctrl_pkg::*;

   localparam int NEG = -100000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] t_rc_m1 = '0, t_rcd_m1 = '0, t_rp_m1 = '0, t_ras_m1 = '0;
   logic [7:0] t_rtp_m1 = '0, t_wtp_m1 = '0, t_ccd_m1 = '0, row_open_cnt = 8'd255;
   logic req_valid = 1'b0, req_wr = 1'b0;
   logic req_ready;
   logic [AXI_ID_WIDTH-1:0]  req_id = '0;
   logic [DRAM_RA_WIDTH-1:0] req_ra = '0;
   logic [DRAM_CA_WIDTH-1:0] req_ca = '0;
   logic [AXI_LEN_WIDTH-1:0] req_len = '0;
   logic act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic [DRAM_BA_WIDTH-1:0] ba;
   logic [DRAM_RA_WIDTH-1:0] ra;
   logic [DRAM_CA_WIDTH-1:0] ca;
   logic [AXI_ID_WIDTH-1:0]  id;
   logic [AXI_LEN_WIDTH-1:0] len;

   modport_bank_ctrl #(.BK_ID(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .t_rc_m1(t_rc_m1), .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
      .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .t_ccd_m1(t_ccd_m1),
      .row_open_cnt(row_open_cnt),
      .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ra(req_ra),
      .req_ca(req_ca), .req_wr(req_wr), .req_len(req_len),
      .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
      .ba(ba), .ra(ra), .ca(ca), .id(id), .len(len));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // reference model: bank open flag, open row, and cycle stamps of past commands
   int  cyc = 0;
   bit  m_open = 0;
   logic [DRAM_RA_WIDTH-1:0] m_row = '0;
   int  s_act = NEG, s_pre = NEG, s_rd = NEG, s_wr = NEG, s_rdwr = NEG, s_gnt = NEG;
   bit  accepted = 0;
   int  d_act = 0, d_rd = 0, d_wr = 0, d_pre = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit elapsed(input int stamp, input logic [7:0] m1);
      return cyc >= stamp + int'(m1) + 1;
   endfunction

   task automatic cycle();
      bit e_act, e_rd, e_wr, e_pre, hit_ok, miss, idle_full;
      logic [DRAM_RA_WIDTH-1:0] e_ra;
      @(negedge clk);
      e_act = rst_n && !m_open && req_valid && elapsed(s_pre, t_rp_m1) && elapsed(s_act, t_rc_m1);
      hit_ok = rst_n && m_open && req_valid && (req_ra == m_row)
               && elapsed(s_act, t_rcd_m1) && elapsed(s_rdwr, t_ccd_m1);
      e_rd = hit_ok && !req_wr;
      e_wr = hit_ok && req_wr;
      miss = req_valid && (req_ra != m_row);
      idle_full = !req_valid && (cyc - s_gnt - 1 >= int'(row_open_cnt));
      e_pre = rst_n && m_open && (miss || idle_full) && elapsed(s_act, t_ras_m1)
              && elapsed(s_rd, t_rtp_m1) && elapsed(s_wr, t_wtp_m1);
      e_ra = e_act ? req_ra : m_row;
      chk("grants", {27'd0, act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt},
          {27'd0, e_act, e_rd, e_wr, e_pre, 1'b0});
      chk("req_ready", 32'(req_ready), 32'(e_rd | e_wr));
      if (e_act || e_pre) chk("ra", 32'(ra), 32'(e_ra));
      if (e_rd || e_wr) begin
         chk("ca", 32'(ca), 32'(req_ca));
         chk("id", 32'(id), 32'(req_id));
         chk("len", 32'(len), 32'(req_len));
      end
      if (act_gnt) d_act = cyc;
      if (rd_gnt)  d_rd  = cyc;
      if (wr_gnt)  d_wr  = cyc;
      if (pre_gnt) d_pre = cyc;
      accepted = e_rd | e_wr;
      @(posedge clk);
      if (!rst_n) begin
         m_open = 0; m_row = '0;
         s_act = NEG; s_pre = NEG; s_rd = NEG; s_wr = NEG; s_rdwr = NEG; s_gnt = NEG;
      end else begin
         if (e_act) begin m_open = 1; m_row = req_ra; s_act = cyc; s_gnt = cyc; end
         if (e_rd)  begin s_rd = cyc; s_rdwr = cyc; s_gnt = cyc; end
         if (e_wr)  begin s_wr = cyc; s_rdwr = cyc; s_gnt = cyc; end
         if (e_pre) begin m_open = 0; s_pre = cyc; s_gnt = cyc; end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset(input logic [7:0] rc, rcd, rp, ras, rtp, wtp, ccd, roc);
      rst_n = 1'b0;
      t_rc_m1 = rc; t_rcd_m1 = rcd; t_rp_m1 = rp; t_ras_m1 = ras;
      t_rtp_m1 = rtp; t_wtp_m1 = wtp; t_ccd_m1 = ccd; row_open_cnt = roc;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   task automatic do_req(input int row, input int col, input bit wr, input int rid, input int budget);
      int n;
      req_ra = DRAM_RA_WIDTH'(row); req_ca = DRAM_CA_WIDTH'(col); req_wr = wr;
      req_id = AXI_ID_WIDTH'(rid); req_len = AXI_LEN_WIDTH'($urandom);
      req_valid = 1'b1;
      n = 0;
      accepted = 0;
      while (!accepted && n < budget) begin
         cycle();
         n++;
      end
      if (!accepted) chk("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      int a1, w1;
      bit pend;
      int gap;
      int rows[4] = '{3, 5, 9, 12};

      // reset held 3 cycles with a request pending: nothing may be granted
      req_valid = 1'b1; req_ra = 14'd7;
      rst_n = 1'b0;
      repeat (3) cycle();
      chk("rst_state", 32'(dut.state), 32'(ST_CLOSED));
      chk("ba", 32'(ba), 32'd2);
      req_valid = 1'b0;

      // cold read: ACT then RD four cycles later
      do_reset(0, 3, 0, 0, 0, 0, 0, 255);
      do_req(5, 8, 0, 1, 20);
      chk("cold_rd_lat", 32'(d_rd - d_act), 32'd4);

      // row-hit write stream at t_ccd_m1=1
      do_reset(0, 0, 0, 0, 0, 0, 1, 255);
      do_req(5, 1, 1, 3, 20);
      w1 = d_wr;
      do_req(5, 2, 1, 4, 20);
      chk("ccd_gap1", 32'(d_wr - w1), 32'd2);
      w1 = d_wr;
      do_req(5, 3, 1, 5, 20);
      chk("ccd_gap2", 32'(d_wr - w1), 32'd2);

      // row miss after a write to row 5
      do_reset(0, 0, 2, 7, 0, 0, 0, 255);
      do_req(5, 4, 1, 6, 20);
      a1 = d_act;
      do_req(9, 5, 1, 7, 40);
      chk("miss_pre_lat", 32'(d_pre - a1), 32'd8);
      chk("miss_act_lat", 32'(d_act - d_pre), 32'd3);

      // auto-precharge after 10 idle cycles
      do_reset(0, 0, 0, 0, 3, 0, 0, 10);
      do_req(5, 6, 0, 8, 20);
      repeat (15) cycle();
      chk("auto_pre_lat", 32'(d_pre - d_rd), 32'd11);

      // tRC bound between two ACTs
      do_reset(20, 0, 2, 2, 0, 0, 0, 255);
      do_req(5, 7, 0, 9, 20);
      a1 = d_act;
      do_req(9, 7, 0, 10, 60);
      chk("trc_act_gap", 32'(d_act - a1), 32'd21);

      // randomized traffic against the reference model
      for (int r = 0; r < 6; r++) begin
         do_reset(8'($urandom_range(0, 15)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  8'($urandom_range(0, 3)), 8'($urandom_range(0, 12)));
         pend = 0;
         gap = 0;
         for (int c = 0; c < 500; c++) begin
            if (!pend && gap == 0) begin
               pend = 1;
               req_ra  = DRAM_RA_WIDTH'(rows[$urandom_range(0, 3)]);
               req_ca  = DRAM_CA_WIDTH'($urandom);
               req_wr  = 1'($urandom);
               req_id  = AXI_ID_WIDTH'($urandom);
               req_len = AXI_LEN_WIDTH'($urandom);
            end else if (!pend) begin
               gap--;
            end
            req_valid = pend;
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cycle();
            if (accepted) begin
               pend = 0;
               gap = $urandom_range(0, 14);
            end
         end
         rst_n = 1'b1;
         req_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modport_bank_ctrl.md
# modport_bank_ctrl

Single-bank DRAM bank controller for the STEP1 memory controller. It accepts column requests on a valid/ready request channel and tracks the open-row state of one bank. It enforces the intra-bank timing parameters and issues one-cycle ACT/RD/WR/PRE grants, with their address and ID fields, toward the command encoder and the read/write data controllers. STEP1 has no arbiter: grants come directly from this block, and the scheduler `*_req` signals are not driven.

## Interface
Parameters:
- BK_ID, default 0: bank index driven on `ba`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_ccd_m1  in  `T_*_WIDTH`  timing value minus 1; quasi-static.
- row_open_cnt  in  `ROW_OPEN_WIDTH`  idle cycles before auto-precharge.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted.
- req_id  in  `AXI_ID_WIDTH`  request ID.
- req_ra  in  `DRAM_RA_WIDTH`  row address.
- req_ca  in  `DRAM_CA_WIDTH`  column address.
- req_wr  in  1  1 = write.
- req_len  in  `AXI_LEN_WIDTH`  burst length.
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  1  command grants.
- ba  out  `DRAM_BA_WIDTH`  bank address; constant BK_ID.
- ra  out  `DRAM_RA_WIDTH`  row address.
- ca  out  `DRAM_CA_WIDTH`  column address.
- id  out  `AXI_ID_WIDTH`  request ID.
- len  out  `AXI_LEN_WIDTH`  burst length.

## Operation
- FSM states: CLOSED (reset state) and OPEN. The open row is held in register `cur_row`.
- Timers (tRCD, tRP, tRAS, tRC, tRTP, tWTP, tCCD) are down-counters.
  - Each loads its `*_m1` value on the triggering command and decrements to 0, saturating there.
  - A command is legal only when all relevant timers are 0.
- CLOSED: if `req_valid` && tRP==0 && tRC==0:
  - assert `act_gnt` with `ra=req_ra`;
  - latch `cur_row`;
  - load tRCD, tRAS, tRC;
  - go to OPEN.
- OPEN, hit (`req_valid` && `req_ra==cur_row` && tRCD==0 && tCCD==0):
  - assert `rd_gnt` (req_wr=0) or `wr_gnt` (req_wr=1), with `req_ready=1` in the same cycle;
  - load tCCD, and tRTP (read) or tWTP (write);
  - clear the idle counter.
- OPEN, precharge condition: (`req_valid` && miss), or (!`req_valid` && idle counter == row_open_cnt).
  - Precharge issues when tRAS==0 && tRTP==0 && tWTP==0.
  - Then assert `pre_gnt` with `ra=cur_row`, load tRP, and go to CLOSED.
  - The missing request is served later by ACT, then RD/WR.
- Idle counter: increments each OPEN cycle with no grant, saturating at row_open_cnt.
- `req_ready` is combinational and equals `rd_gnt|wr_gnt`. A request is never accepted on ACT or PRE.
- At most one grant is asserted per cycle. `ref_gnt` is tied to 0 in STEP1.
- Output fields:
  - `ca`, `id`, `len` pass `req_*` through;
  - `ra = req_ra` on ACT, otherwise `cur_row`.
- Reset: state CLOSED, all timers 0, idle counter 0, `cur_row` 0, all grants and `req_ready` 0.
- Reset asserted mid-operation aborts the current state with no grant.

## Timing
- Grants are combinational from the current state, timers and request. State and timers update at the posedge.
- Command at cycle t with value m1: the dependent command is earliest at t+m1+1.
  - ACT→RD/WR ≥ t_rcd_m1+1
  - ACT→PRE ≥ t_ras_m1+1
  - PRE→ACT ≥ t_rp_m1+1
  - ACT→ACT ≥ t_rc_m1+1
  - RD→PRE ≥ t_rtp_m1+1
  - WR→PRE ≥ t_wtp_m1+1
  - RD/WR→RD/WR ≥ t_ccd_m1+1
- `req_valid` held with no grant stalls without penalty. Request fields must be stable until `req_ready`.
- Back-to-back hits issue every t_ccd_m1+1 cycles.

## Structure
- Shared package: state enum {CLOSED, OPEN}. Width macros come from `SAL_DDR_PARAMS.svh`.
- Sub-module `modport_bank_timer`: parameterized-width, load-and-count-down-to-zero timer with an `is_zero` output. Instantiate it once per timing parameter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all grants 0, `req_ready`=0, state CLOSED.
- Cold read: t_rcd_m1=3, ra=5, ca=8, wr=0 → ACT at cycle t (ra=5), RD at t+4 with `req_ready`=1, ca=8.
- Row hit stream: 3 writes to the same row, t_ccd_m1=1 → WR grants 2 cycles apart; IDs are passed through.
- Row miss: open row 5, t_ras_m1=7, request row 9 → PRE no earlier than ACT+8 (ra=5); ACT row 9 at PRE+t_rp_m1+1; then WR.
- Auto-precharge: row_open_cnt=10, no requests after a RD → PRE after 10 idle cycles and after tRTP has expired.
- tRC bound: t_rc_m1=20, t_ras_m1=2, t_rp_m1=2, immediate miss → second ACT not before first ACT+21.
